// File: rtl/snn_pkg.sv
// Shared constants for the pattern-recognition SNN core.
// Holds the fixed synaptic weight tables (input->hidden, hidden->output),
// the weight width, the activity counter width and the activity decay period.
package snn_pkg;

  localparam int WEIGHT_W     = 6;
  localparam int ACT_W        = 8;
  localparam int DECAY_PERIOD = 128;
  localparam int DECAY_CNT_W  = $clog2(DECAY_PERIOD);

  localparam int N_IN  = 4;
  localparam int N_HID = 8;
  localparam int N_OUT = 3;

  typedef logic signed [WEIGHT_W-1:0] weight_t;

  // Row = hidden neuron, column = input pixel (in0..in3).
  localparam weight_t W_IH [N_HID][N_IN] = '{
    '{ 6'sd3, -6'sd4,  6'sd3,  6'sd3},  // h0: L detector
    '{ 6'sd3, -6'sd4,  6'sd3,  6'sd3},  // h1: L detector
    '{ 6'sd3,  6'sd3, -6'sd4,  6'sd3},  // h2: T detector
    '{ 6'sd3,  6'sd3, -6'sd4,  6'sd3},  // h3: T detector
    '{-6'sd4,  6'sd3,  6'sd3,  6'sd3},  // h4: Cross detector
    '{-6'sd4,  6'sd3,  6'sd3,  6'sd3},  // h5: Cross detector
    '{ 6'sd2,  6'sd2,  6'sd2,  6'sd2},  // h6: general activity
    '{ 6'sd2,  6'sd2,  6'sd2,  6'sd2}   // h7: general activity
  };

  // Row = output neuron, column = hidden neuron (h0..h7).
  // Each class excites its own detector pair and inhibits the others.
  localparam weight_t W_HO [N_OUT][N_HID] = '{
    '{ 6'sd16,  6'sd16, -6'sd8,  -6'sd8,  -6'sd8,  -6'sd8,  6'sd0, 6'sd0},
    '{-6'sd8,  -6'sd8,   6'sd16,  6'sd16, -6'sd8,  -6'sd8,  6'sd0, 6'sd0},
    '{-6'sd8,  -6'sd8,  -6'sd8,  -6'sd8,   6'sd16,  6'sd16, 6'sd0, 6'sd0}
  };

endpackage

// File: rtl/snn_core_pattern_recognition_lif_neuron.sv
// lif_neuron: one leaky integrate-and-fire neuron.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_wsum    - signed weighted sum of this cycle's presynaptic spikes
//   i_bias    - signed 4-bit per-cycle bias
//   o_spike   - registered spike, high for one cycle after threshold crossing
//   o_pot     - registered membrane potential (unsigned, WIDTH bits)
module lif_neuron #(
  parameter int THRESHOLD = 20,
  parameter int LEAK      = 1,
  parameter int WIDTH     = 8,
  parameter int SUM_W     = WIDTH + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [SUM_W-1:0] i_wsum,
  input  logic signed [3:0]       i_bias,
  output logic                    o_spike,
  output logic [WIDTH-1:0]        o_pot
);

  localparam logic signed [SUM_W-1:0] POT_MAX = SUM_W'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0]        THR     = WIDTH'(THRESHOLD);

  function automatic logic [WIDTH-1:0] clamp_pot(input logic signed [SUM_W-1:0] s);
    if (s < 0)            clamp_pot = '0;
    else if (s > POT_MAX) clamp_pot = '1;
    else                  clamp_pot = s[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0]        r_pot;
  logic                    r_spike;
  logic signed [SUM_W-1:0] w_sum;
  logic [WIDTH-1:0]        w_clamp;
  logic                    w_fire;

  // The sum is wide enough that pot + inputs + bias - leak cannot wrap
  // before the clamp.
  assign w_sum   = $signed({{(SUM_W-WIDTH){1'b0}}, r_pot}) + i_wsum
                   + SUM_W'(i_bias) - SUM_W'(LEAK);
  assign w_clamp = clamp_pot(w_sum);
  assign w_fire  = (w_clamp >= THR);

  // p0 -> p1: potential and spike registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pot   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_spike <= w_fire;
      r_pot   <= w_fire ? '0 : w_clamp;
    end
  end

  assign o_spike = r_spike;
  assign o_pot   = r_pot;

endmodule

// File: rtl/snn_core_pattern_recognition.sv
// snn_core_pattern_recognition: 4-input, 8-hidden, 3-output spiking network
// classifying L / T / Cross pixel spike patterns.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   spike_in_0..3                 - pixel spikes (one-cycle pulses)
//   bias_output_0..2              - signed 4-bit per-cycle bias to output k
//   spike_out_0..2                - registered output neuron spikes
//   winner                        - registered argmax of output activity
//   pot_h0..7, pot_o0..2          - debug membrane potentials
// Build option: define SNN_DEBUG_POT_EN to expose the live potentials on the
// pot_* ports; otherwise they are tied to 0. The network behaves identically.
module snn_core_pattern_recognition
  import snn_pkg::*;
#(
  parameter int THRESHOLD_HIDDEN = 20,
  parameter int THRESHOLD_OUTPUT = 15,
  parameter int LEAK             = 1,
  parameter int POTENTIAL_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spike_in_0,
  input  logic                       spike_in_1,
  input  logic                       spike_in_2,
  input  logic                       spike_in_3,
  input  logic [3:0]                 bias_output_0,
  input  logic [3:0]                 bias_output_1,
  input  logic [3:0]                 bias_output_2,
  output logic                       spike_out_0,
  output logic                       spike_out_1,
  output logic                       spike_out_2,
  output logic [1:0]                 winner,
  output logic [POTENTIAL_WIDTH-1:0] pot_h0,
  output logic [POTENTIAL_WIDTH-1:0] pot_h1,
  output logic [POTENTIAL_WIDTH-1:0] pot_h2,
  output logic [POTENTIAL_WIDTH-1:0] pot_h3,
  output logic [POTENTIAL_WIDTH-1:0] pot_h4,
  output logic [POTENTIAL_WIDTH-1:0] pot_h5,
  output logic [POTENTIAL_WIDTH-1:0] pot_h6,
  output logic [POTENTIAL_WIDTH-1:0] pot_h7,
  output logic [POTENTIAL_WIDTH-1:0] pot_o0,
  output logic [POTENTIAL_WIDTH-1:0] pot_o1,
  output logic [POTENTIAL_WIDTH-1:0] pot_o2
);

  localparam int SUM_W = POTENTIAL_WIDTH + 4;

`ifdef SNN_DEBUG_POT_EN
  localparam bit POT_VISIBLE = 1'b1;
`else
  localparam bit POT_VISIBLE = 1'b0;
`endif

  function automatic logic [ACT_W-1:0] act_update(input logic [ACT_W-1:0] a,
                                                  input logic decay,
                                                  input logic inc);
    logic [ACT_W-1:0] base;
    base = decay ? (a >> 1) : a;
    if (inc && (base != '1)) act_update = base + ACT_W'(1);
    else                     act_update = base;
  endfunction

  function automatic logic [1:0] argmax3(input logic [ACT_W-1:0] a0,
                                         input logic [ACT_W-1:0] a1,
                                         input logic [ACT_W-1:0] a2);
    logic [1:0]       idx;
    logic [ACT_W-1:0] best;
    idx  = 2'd0;
    best = a0;
    // Strict compares keep the lowest index on ties.
    if (a1 > best) begin
      idx  = 2'd1;
      best = a1;
    end
    if (a2 > best) idx = 2'd2;
    return idx;
  endfunction

  logic [N_IN-1:0]              w_in;
  logic signed [3:0]            w_bias     [N_OUT];
  logic signed [SUM_W-1:0]      w_hid_wsum [N_HID];
  logic signed [SUM_W-1:0]      w_out_wsum [N_OUT];
  logic [N_HID-1:0]             w_hid_spike;
  logic [N_OUT-1:0]             w_out_spike;
  logic [POTENTIAL_WIDTH-1:0]   w_hid_pot  [N_HID];
  logic [POTENTIAL_WIDTH-1:0]   w_out_pot  [N_OUT];
  logic                         w_decay;

  logic [DECAY_CNT_W-1:0]       r_decay_cnt;
  logic [ACT_W-1:0]             r_act      [N_OUT];
  logic [1:0]                   r_winner;

  assign w_in      = {spike_in_3, spike_in_2, spike_in_1, spike_in_0};
  assign w_bias[0] = bias_output_0;
  assign w_bias[1] = bias_output_1;
  assign w_bias[2] = bias_output_2;

  // All simultaneous presynaptic spikes accumulate in the same cycle.
  always_comb begin
    for (int j = 0; j < N_HID; j++) begin
      w_hid_wsum[j] = '0;
      for (int i = 0; i < N_IN; i++)
        if (w_in[i]) w_hid_wsum[j] = w_hid_wsum[j] + SUM_W'(W_IH[j][i]);
    end
    for (int k = 0; k < N_OUT; k++) begin
      w_out_wsum[k] = '0;
      for (int j = 0; j < N_HID; j++)
        if (w_hid_spike[j]) w_out_wsum[k] = w_out_wsum[k] + SUM_W'(W_HO[k][j]);
    end
  end

  // p0 -> p1: hidden layer (inputs straight from the pixel encoder)
  for (genvar j = 0; j < N_HID; j++) begin : g_hid
    lif_neuron #(
      .THRESHOLD (THRESHOLD_HIDDEN),
      .LEAK      (LEAK),
      .WIDTH     (POTENTIAL_WIDTH),
      .SUM_W     (SUM_W)
    ) u_lif (
      .clk     (clk),
      .rst     (rst),
      .i_wsum  (w_hid_wsum[j]),
      .i_bias  (4'sd0),
      .o_spike (w_hid_spike[j]),
      .o_pot   (w_hid_pot[j])
    );
  end

  // p1 -> p2: output layer (fed by registered hidden spikes)
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    lif_neuron #(
      .THRESHOLD (THRESHOLD_OUTPUT),
      .LEAK      (LEAK),
      .WIDTH     (POTENTIAL_WIDTH),
      .SUM_W     (SUM_W)
    ) u_lif (
      .clk     (clk),
      .rst     (rst),
      .i_wsum  (w_out_wsum[k]),
      .i_bias  (w_bias[k]),
      .o_spike (w_out_spike[k]),
      .o_pot   (w_out_pot[k])
    );
  end

  // Decay fires on the cycle the free-running counter wraps.
  assign w_decay = (r_decay_cnt == '1);

  // p2 -> p3: activity counters and winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_decay_cnt <= '0;
      r_winner    <= 2'd0;
      for (int k = 0; k < N_OUT; k++) r_act[k] <= '0;
    end else begin
      r_decay_cnt <= r_decay_cnt + DECAY_CNT_W'(1);
      for (int k = 0; k < N_OUT; k++)
        r_act[k] <= act_update(r_act[k], w_decay, w_out_spike[k]);
      r_winner <= argmax3(r_act[0], r_act[1], r_act[2]);
    end
  end

  assign spike_out_0 = w_out_spike[0];
  assign spike_out_1 = w_out_spike[1];
  assign spike_out_2 = w_out_spike[2];
  assign winner      = r_winner;

  assign pot_h0 = POT_VISIBLE ? w_hid_pot[0] : '0;
  assign pot_h1 = POT_VISIBLE ? w_hid_pot[1] : '0;
  assign pot_h2 = POT_VISIBLE ? w_hid_pot[2] : '0;
  assign pot_h3 = POT_VISIBLE ? w_hid_pot[3] : '0;
  assign pot_h4 = POT_VISIBLE ? w_hid_pot[4] : '0;
  assign pot_h5 = POT_VISIBLE ? w_hid_pot[5] : '0;
  assign pot_h6 = POT_VISIBLE ? w_hid_pot[6] : '0;
  assign pot_h7 = POT_VISIBLE ? w_hid_pot[7] : '0;
  assign pot_o0 = POT_VISIBLE ? w_out_pot[0] : '0;
  assign pot_o1 = POT_VISIBLE ? w_out_pot[1] : '0;
  assign pot_o2 = POT_VISIBLE ? w_out_pot[2] : '0;

endmodule

// File: tb/tb_snn_core_pattern_recognition.sv
// Testbench for snn_core_pattern_recognition: a cycle reference model pushes
// the expected outputs for every clock edge into a scoreboard queue, and a
// monitor pops and compares on the falling edge. Directed phases add
// hand-computed spike counts, latencies and winner values.
module tb_snn_core_pattern_recognition;

  localparam int W    = 8;
  localparam int TH_H = 20;
  localparam int TH_O = 15;
  localparam int LK   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         spike_in_0 = 1'b0, spike_in_1 = 1'b0, spike_in_2 = 1'b0, spike_in_3 = 1'b0;
  logic [3:0]   bias_output_0 = 4'd0, bias_output_1 = 4'd0, bias_output_2 = 4'd0;
  logic         spike_out_0, spike_out_1, spike_out_2;
  logic [1:0]   winner;
  logic [W-1:0] pot_h0, pot_h1, pot_h2, pot_h3, pot_h4, pot_h5, pot_h6, pot_h7;
  logic [W-1:0] pot_o0, pot_o1, pot_o2;

  snn_core_pattern_recognition #(
    .THRESHOLD_HIDDEN (TH_H),
    .THRESHOLD_OUTPUT (TH_O),
    .LEAK             (LK),
    .POTENTIAL_WIDTH  (W)
  ) dut (
    .clk (clk), .rst (rst),
    .spike_in_0 (spike_in_0), .spike_in_1 (spike_in_1),
    .spike_in_2 (spike_in_2), .spike_in_3 (spike_in_3),
    .bias_output_0 (bias_output_0), .bias_output_1 (bias_output_1),
    .bias_output_2 (bias_output_2),
    .spike_out_0 (spike_out_0), .spike_out_1 (spike_out_1), .spike_out_2 (spike_out_2),
    .winner (winner),
    .pot_h0 (pot_h0), .pot_h1 (pot_h1), .pot_h2 (pot_h2), .pot_h3 (pot_h3),
    .pot_h4 (pot_h4), .pot_h5 (pot_h5), .pot_h6 (pot_h6), .pot_h7 (pot_h7),
    .pot_o0 (pot_o0), .pot_o1 (pot_o1), .pot_o2 (pot_o2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0]     sp;
    logic [1:0]     win;
    logic [8*W-1:0] ph;
    logic [3*W-1:0] po;
  } exp_t;

  exp_t sbq[$];

  // Reference weights taken directly from the network description.
  int wh [8][4] = '{'{3,-4,3,3}, '{3,-4,3,3}, '{3,3,-4,3}, '{3,3,-4,3},
                    '{-4,3,3,3}, '{-4,3,3,3}, '{2,2,2,2},  '{2,2,2,2}};
  int wo [3][8] = '{'{16,16,-8,-8,-8,-8,0,0},
                    '{-8,-8,16,16,-8,-8,0,0},
                    '{-8,-8,-8,-8,16,16,0,0}};

  int m_ph [8];
  int m_po [3];
  int m_act[3];
  bit m_hs [8];
  bit m_os [3];
  int m_dcnt;
  int m_win;

  initial begin
    for (int j = 0; j < 8; j++) begin m_ph[j] = 0; m_hs[j] = 0; end
    for (int k = 0; k < 3; k++) begin m_po[k] = 0; m_os[k] = 0; m_act[k] = 0; end
    m_dcnt = 0;
    m_win  = 0;
  end

  function automatic int clampi(input int s);
    if (s < 0)   return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // Reference model: advances on every rising edge, queues the expectation.
  always @(posedge clk) begin : model
    int   in_v [4];
    int   bias [3];
    bit   nhs  [8];
    bit   nos  [3];
    int   nact [3];
    int   s, a, best, bi;
    exp_t e;
    if (rst) begin
      for (int j = 0; j < 8; j++) begin m_ph[j] = 0; m_hs[j] = 0; end
      for (int k = 0; k < 3; k++) begin m_po[k] = 0; m_os[k] = 0; m_act[k] = 0; end
      m_dcnt = 0;
      m_win  = 0;
    end else begin
      in_v[0] = int'(spike_in_0); in_v[1] = int'(spike_in_1);
      in_v[2] = int'(spike_in_2); in_v[3] = int'(spike_in_3);
      bias[0] = int'($signed(bias_output_0));
      bias[1] = int'($signed(bias_output_1));
      bias[2] = int'($signed(bias_output_2));
      for (int j = 0; j < 8; j++) begin
        s = m_ph[j] - LK;
        for (int i = 0; i < 4; i++) s += wh[j][i] * in_v[i];
        s = clampi(s);
        nhs[j] = (s >= TH_H);
        m_ph[j] = nhs[j] ? 0 : s;
      end
      for (int k = 0; k < 3; k++) begin
        s = m_po[k] + bias[k] - LK;
        for (int j = 0; j < 8; j++) if (m_hs[j]) s += wo[k][j];
        s = clampi(s);
        nos[k] = (s >= TH_O);
        m_po[k] = nos[k] ? 0 : s;
      end
      for (int k = 0; k < 3; k++) begin
        a = m_act[k];
        if (m_dcnt == 127) a = a / 2;
        if (m_os[k] && a < 255) a = a + 1;
        nact[k] = a;
      end
      best = m_act[0]; bi = 0;
      for (int k = 1; k < 3; k++) if (m_act[k] > best) begin best = m_act[k]; bi = k; end
      m_win  = bi;
      m_dcnt = (m_dcnt + 1) % 128;
      for (int j = 0; j < 8; j++) m_hs[j] = nhs[j];
      for (int k = 0; k < 3; k++) begin m_os[k] = nos[k]; m_act[k] = nact[k]; end
    end
    e.sp  = {m_os[2], m_os[1], m_os[0]};
    e.win = 2'(m_win);
    e.ph  = '0;
    e.po  = '0;
`ifdef SNN_DEBUG_POT_EN
    for (int j = 0; j < 8; j++) e.ph[j*W +: W] = m_ph[j][W-1:0];
    for (int k = 0; k < 3; k++) e.po[k*W +: W] = m_po[k][W-1:0];
`endif
    sbq.push_back(e);
  end

  // Monitor: compares the DUT against the queued expectation each cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_spikes", {spike_out_2, spike_out_1, spike_out_0}, e.sp);
      chk("sb_winner", winner, e.win);
      chk("sb_pots", {pot_h7, pot_h6, pot_h5, pot_h4, pot_h3, pot_h2, pot_h1, pot_h0,
                      pot_o2, pot_o1, pot_o0}, {e.ph, e.po});
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives n cycles; input i pulses when t % p_i == 0 (p_i == 0: silent).
  // Counts output spikes seen after each edge, and the edge of the first O0 spike.
  task automatic run(input int n, input int p0, input int p1, input int p2, input int p3,
                     output int c0, output int c1, output int c2, output int first0);
    c0 = 0; c1 = 0; c2 = 0; first0 = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      spike_in_0 = (p0 == 0) ? 1'b0 : (t % p0 == 0);
      spike_in_1 = (p1 == 0) ? 1'b0 : (t % p1 == 0);
      spike_in_2 = (p2 == 0) ? 1'b0 : (t % p2 == 0);
      spike_in_3 = (p3 == 0) ? 1'b0 : (t % p3 == 0);
      @(posedge clk);
      #1;
      c0 += int'(spike_out_0);
      c1 += int'(spike_out_1);
      c2 += int'(spike_out_2);
      if (spike_out_0 === 1'b1 && first0 == 0) first0 = t + 1;
    end
  endtask

  initial begin : stim
    int c0, c1, c2, f0;

    do_reset(3);
    chk("rst_spikes", {spike_out_2, spike_out_1, spike_out_0}, 3'b000);
    chk("rst_winner", winner, 2'd0);
    chk("rst_pots", {pot_h7, pot_h6, pot_h5, pot_h4, pot_h3, pot_h2, pot_h1, pot_h0,
                     pot_o2, pot_o1, pot_o0}, '0);

    // Bias +3 on O2 alone: +2 per cycle, fires at 16 -> every 8 cycles.
    bias_output_2 = 4'd3;
    run(80, 0, 0, 0, 0, c0, c1, c2, f0);
    chk("bias_o2_count", c2, 10);
    chk("bias_o0_count", c0, 0);
    chk("bias_o1_count", c1, 0);

    // Max positive bias fires every 3 cycles; -8 clamps at 0 and never fires.
    bias_output_0 = 4'd7;
    bias_output_1 = 4'b1000;
    bias_output_2 = 4'd0;
    run(30, 0, 0, 0, 0, c0, c1, c2, f0);
    chk("bias7_o0_count", c0, 10);
    chk("biasneg_o1_count", c1, 0);
    chk("bias0_o2_count", c2, 0);

    // Held L pixels: h0/h1 fire at edge 3, O0 fires one layer later at edge 4.
    bias_output_0 = 4'd0;
    bias_output_1 = 4'd0;
    do_reset(1);
    run(12, 1, 0, 1, 1, c0, c1, c2, f0);
    chk("l_hold_o0_first", f0, 4);
    chk("l_hold_o0_count", c0, 3);
    chk("l_hold_o1_count", c1, 0);
    chk("l_hold_o2_count", c2, 0);

    // Pattern L.
    do_reset(2);
    run(2000, 5, 10, 5, 5, c0, c1, c2, f0);
    chk("L_o0_active", (c0 > 0), 1'b1);
    chk("L_o1_count", c1, 0);
    chk("L_o2_count", c2, 0);
    chk("L_winner", winner, 2'd0);

    // Pattern T (in2 quiet), after a quiet gap to drain hidden potentials.
    run(25, 0, 0, 0, 0, c0, c1, c2, f0);
    run(2000, 5, 5, 0, 5, c0, c1, c2, f0);
    chk("T_o1_active", (c1 > 0), 1'b1);
    chk("T_o0_count", c0, 0);
    chk("T_o2_count", c2, 0);
    chk("T_winner", winner, 2'd1);

    // Pattern Cross (in0 quiet) with +3 bias on O2.
    run(25, 0, 0, 0, 0, c0, c1, c2, f0);
    bias_output_2 = 4'd3;
    run(2000, 0, 5, 5, 5, c0, c1, c2, f0);
    chk("X_o2_active", (c2 >= 250), 1'b1);
    chk("X_o0_count", c0, 0);
    chk("X_o1_count", c1, 0);
    chk("X_winner", winner, 2'd2);

    // Sparse input on all pixels: nothing reaches threshold.
    bias_output_2 = 4'd0;
    run(25, 0, 0, 0, 0, c0, c1, c2, f0);
    run(500, 10, 10, 10, 10, c0, c1, c2, f0);
    chk("quiet_o0_count", c0, 0);
    chk("quiet_o1_count", c1, 0);
    chk("quiet_o2_count", c2, 0);

    // One-cycle reset in the middle of pattern L activity.
    bias_output_0 = 4'd5;
    run(60, 5, 10, 5, 5, c0, c1, c2, f0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_spikes", {spike_out_2, spike_out_1, spike_out_0}, 3'b000);
    chk("midrst_winner", winner, 2'd0);
    chk("midrst_pots", {pot_h7, pot_h6, pot_h5, pot_h4, pot_h3, pot_h2, pot_h1, pot_h0,
                        pot_o2, pot_o1, pot_o0}, '0);
    bias_output_0 = 4'd0;
    run(50, 5, 10, 5, 5, c0, c1, c2, f0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
